// File: rtl/lfsr_fill.sv
// rtl/lfsr_fill.sv - fills shared BRAM with a Galois LFSR sequence, then reads it back and counts mismatches
module lfsr_fill #(
  parameter int          NWORDS = 2048,
  parameter int          ADDR_W = 13,
  parameter logic [31:0] POLY   = 32'h80200003
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ps_control,
  output logic [31:0]       pl_status,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [31:0]       bram_rddata,
  output logic [31:0]       bram_wrdata,
  output logic [3:0]        bram_we
);

  localparam int CW = $clog2(NWORDS) + 1;
  localparam logic [CW-1:0] LAST  = CW'(NWORDS - 1);
  localparam logic [CW-1:0] DRAIN = CW'(NWORDS);

  typedef enum logic [2:0] {IDLE, FILL, VERIFY, REPORT, DONE} state_t;

  state_t         state;
  logic [31:0]    seed;
  logic [31:0]    lfsr;
  logic [CW-1:0]  cnt;
  logic [11:0]    mis_cnt;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      seed        <= '0;
      lfsr        <= '0;
      cnt         <= '0;
      mis_cnt     <= '0;
      pl_status   <= '0;
      bram_addr   <= '0;
      bram_wrdata <= '0;
      bram_we     <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          bram_we <= 4'h0;
          if (ps_control[0]) begin
            seed        <= {ps_control[31:1], 1'b1};
            bram_addr   <= '0;
            bram_wrdata <= {ps_control[31:1], 1'b1};
            bram_we     <= 4'hf;
            mis_cnt     <= '0;
            cnt         <= '0;
            state       <= FILL;
          end
        end
        // bram_wrdata doubles as the fill-side LFSR register
        FILL: begin
          if (cnt == LAST) begin
            bram_we   <= 4'h0;
            bram_addr <= '0;
            lfsr      <= seed;
            cnt       <= '0;
            state     <= VERIFY;
          end else begin
            bram_addr   <= bram_addr + ADDR_W'(4);
            bram_wrdata <= lfsr_step(bram_wrdata);
            cnt         <= cnt + 1'b1;
          end
        end
        // cnt-th edge issues address cnt+1 and checks word cnt-1 (read data lags two edges)
        VERIFY: begin
          if (cnt < LAST)
            bram_addr <= bram_addr + ADDR_W'(4);
          if (cnt != '0) begin
            if (bram_rddata != lfsr && mis_cnt != 12'hfff)
              mis_cnt <= mis_cnt + 1'b1;
            lfsr <= lfsr_step(lfsr);
          end
          if (cnt == DRAIN)
            state <= REPORT;
          else
            cnt <= cnt + 1'b1;
        end
        REPORT: begin
          pl_status <= {4'b0, mis_cnt, 14'b0, (mis_cnt != 12'd0), 1'b1};
          state     <= DONE;
        end
        DONE: begin
          if (!ps_control[0]) begin
            pl_status <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
